// File: rtl/axi_lite_regfile.sv
// rtl/axi_lite_regfile.sv - parametrised AXI4-Lite control/status register file
// Writable slots hold state; RO_MASK slots read back hw_status and reject writes.
module axi_lite_regfile #(
  parameter int                   DATA_W   = 32,
  parameter int                   ADDR_W   = 32,
  parameter int                   NUM_REGS = 8,
  parameter logic [NUM_REGS-1:0]  RO_MASK  = '0,
  parameter logic [DATA_W-1:0]    RST_VAL  = '0
) (
  input  logic                         aclk,
  input  logic                         aresetn,

  input  logic [ADDR_W-1:0]            s_axi_awaddr,
  input  logic [2:0]                   s_axi_awprot,
  input  logic                         s_axi_awvalid,
  output logic                         s_axi_awready,

  input  logic [DATA_W-1:0]            s_axi_wdata,
  input  logic [DATA_W/8-1:0]          s_axi_wstrb,
  input  logic                         s_axi_wvalid,
  output logic                         s_axi_wready,

  output logic [1:0]                   s_axi_bresp,
  output logic                         s_axi_bvalid,
  input  logic                         s_axi_bready,

  input  logic [ADDR_W-1:0]            s_axi_araddr,
  input  logic [2:0]                   s_axi_arprot,
  input  logic                         s_axi_arvalid,
  output logic                         s_axi_arready,

  output logic [DATA_W-1:0]            s_axi_rdata,
  output logic [1:0]                   s_axi_rresp,
  output logic                         s_axi_rvalid,
  input  logic                         s_axi_rready,

  output logic [NUM_REGS*DATA_W-1:0]   reg_out,
  input  logic [NUM_REGS*DATA_W-1:0]   hw_status,
  output logic [NUM_REGS-1:0]          wr_pulse
);

  localparam int STRB_W = DATA_W / 8;
  localparam int LSB    = $clog2(STRB_W);
  localparam int IDX_W  = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  logic                live;
  logic                aw_pending;
  logic                w_pending;
  logic [ADDR_W-1:0]   aw_addr_q;
  logic [DATA_W-1:0]   w_data_q;
  logic [STRB_W-1:0]   w_strb_q;
  logic [DATA_W-1:0]   regs_q [NUM_REGS];

  logic [ADDR_W-1:0]   aw_word;
  logic                aw_hit;
  logic [IDX_W-1:0]    aw_idx;
  logic                aw_ro;
  logic                commit;
  logic [DATA_W-1:0]   wmask;

  logic [ADDR_W-1:0]   ar_word;
  logic                ar_hit;
  logic [IDX_W-1:0]    ar_idx;
  logic [DATA_W-1:0]   rd_val;

  logic                unused_prot;
  assign unused_prot = ^{s_axi_awprot, s_axi_arprot};

  // live keeps every ready low while reset is held and for the first edge after it
  assign s_axi_awready = live & ~aw_pending & ~s_axi_bvalid;
  assign s_axi_wready  = live & ~w_pending  & ~s_axi_bvalid;
  assign s_axi_arready = live & ~s_axi_rvalid;

  assign aw_word = aw_addr_q >> LSB;
  assign aw_hit  = aw_word < ADDR_W'(NUM_REGS);
  assign aw_idx  = aw_word[IDX_W-1:0];
  assign commit  = aw_pending & w_pending & ~s_axi_bvalid;

  assign ar_word = s_axi_araddr >> LSB;
  assign ar_hit  = ar_word < ADDR_W'(NUM_REGS);
  assign ar_idx  = ar_word[IDX_W-1:0];

  always_comb begin
    wr_pulse = '0;
    aw_ro    = 1'b0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (aw_idx == IDX_W'(i)) begin
        aw_ro       = RO_MASK[i];
        wr_pulse[i] = commit & aw_hit & ~RO_MASK[i];
      end
    end
  end

  always_comb begin
    wmask = '0;
    for (int b = 0; b < STRB_W; b++) begin
      wmask[b*8 +: 8] = {8{w_strb_q[b]}};
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      live         <= 1'b0;
      aw_pending   <= 1'b0;
      w_pending    <= 1'b0;
      aw_addr_q    <= '0;
      w_data_q     <= '0;
      w_strb_q     <= '0;
      s_axi_bvalid <= 1'b0;
      s_axi_bresp  <= RESP_OKAY;
    end else begin
      live <= 1'b1;
      if (s_axi_awvalid && s_axi_awready) begin
        aw_pending <= 1'b1;
        aw_addr_q  <= s_axi_awaddr;
      end
      if (s_axi_wvalid && s_axi_wready) begin
        w_pending <= 1'b1;
        w_data_q  <= s_axi_wdata;
        w_strb_q  <= s_axi_wstrb;
      end
      // Handshakes cannot coincide with commit: both readies are low while pending
      if (commit) begin
        aw_pending   <= 1'b0;
        w_pending    <= 1'b0;
        s_axi_bvalid <= 1'b1;
        if (!aw_hit)     s_axi_bresp <= RESP_DECERR;
        else if (aw_ro)  s_axi_bresp <= RESP_SLVERR;
        else             s_axi_bresp <= RESP_OKAY;
      end else if (s_axi_bvalid && s_axi_bready) begin
        s_axi_bvalid <= 1'b0;
      end
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= RST_VAL;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (wr_pulse[i]) regs_q[i] <= (regs_q[i] & ~wmask) | (w_data_q & wmask);
      end
    end
  end

  always_comb begin
    reg_out = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      reg_out[i*DATA_W +: DATA_W] = RO_MASK[i] ? '0 : regs_q[i];
    end
  end

  // Sampled against regs_q before this edge's write, so a colliding read sees the old value
  always_comb begin
    rd_val = '0;
    if (ar_hit) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (ar_idx == IDX_W'(i)) begin
          rd_val = RO_MASK[i] ? hw_status[i*DATA_W +: DATA_W] : regs_q[i];
        end
      end
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      s_axi_rvalid <= 1'b0;
      s_axi_rdata  <= '0;
      s_axi_rresp  <= RESP_OKAY;
    end else if (s_axi_arvalid && s_axi_arready) begin
      s_axi_rvalid <= 1'b1;
      s_axi_rdata  <= rd_val;
      s_axi_rresp  <= ar_hit ? RESP_OKAY : RESP_DECERR;
    end else if (s_axi_rvalid && s_axi_rready) begin
      s_axi_rvalid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_axi_lite_regfile.sv
// tb/tb_axi_lite_regfile.sv - directed self-checking bench for axi_lite_regfile
module tb_axi_lite_regfile;
  localparam int             DW   = 32;
  localparam int             AW   = 32;
  localparam int             NR   = 8;
  localparam logic [NR-1:0]  RO   = 8'h01;
  localparam logic [DW-1:0]  RSTV = 32'h5A5A_0000;

  logic              aclk;
  logic              aresetn;
  logic [AW-1:0]     s_axi_awaddr;
  logic [2:0]        s_axi_awprot;
  logic              s_axi_awvalid;
  logic              s_axi_awready;
  logic [DW-1:0]     s_axi_wdata;
  logic [DW/8-1:0]   s_axi_wstrb;
  logic              s_axi_wvalid;
  logic              s_axi_wready;
  logic [1:0]        s_axi_bresp;
  logic              s_axi_bvalid;
  logic              s_axi_bready;
  logic [AW-1:0]     s_axi_araddr;
  logic [2:0]        s_axi_arprot;
  logic              s_axi_arvalid;
  logic              s_axi_arready;
  logic [DW-1:0]     s_axi_rdata;
  logic [1:0]        s_axi_rresp;
  logic              s_axi_rvalid;
  logic              s_axi_rready;
  logic [NR*DW-1:0]  reg_out;
  logic [NR*DW-1:0]  hw_status;
  logic [NR-1:0]     wr_pulse;

  axi_lite_regfile #(
    .DATA_W(DW), .ADDR_W(AW), .NUM_REGS(NR), .RO_MASK(RO), .RST_VAL(RSTV)
  ) dut (
    .aclk(aclk), .aresetn(aresetn),
    .s_axi_awaddr(s_axi_awaddr), .s_axi_awprot(s_axi_awprot),
    .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
    .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb),
    .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
    .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready),
    .s_axi_araddr(s_axi_araddr), .s_axi_arprot(s_axi_arprot),
    .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
    .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
    .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
    .reg_out(reg_out), .hw_status(hw_status), .wr_pulse(wr_pulse)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  int n_cmp = 0;
  int n_bad = 0;
  int pcnt [NR];
  int snap [NR];

  always @(negedge aclk) begin
    for (int i = 0; i < NR; i++) if (wr_pulse[i] === 1'b1) pcnt[i]++;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, n_cmp=%0d", n_cmp);
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [NR*DW-1:0] obs, input logic [NR*DW-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] slot(input int i);
    return reg_out[i*DW +: DW];
  endfunction

  task automatic take_snap();
    for (int i = 0; i < NR; i++) snap[i] = pcnt[i];
  endtask

  function automatic logic [NR-1:0] pulsed();
    logic [NR-1:0] v;
    for (int i = 0; i < NR; i++) v[i] = (pcnt[i] != snap[i]);
    return v;
  endfunction

  task automatic wait_b(output logic [1:0] resp);
    bit got;
    got = 1'b0;
    resp = 2'bxx;
    s_axi_bready = 1'b1;
    for (int k = 0; k < 20 && !got; k++) begin
      if (s_axi_bvalid) begin
        resp = s_axi_bresp;
        got  = 1'b1;
      end
      tick();
    end
    s_axi_bready = 1'b0;
    chk("b_timeout", got, 1);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                    output logic [1:0] resp);
    bit aw_done, w_done, hs_aw, hs_w;
    aw_done = 1'b0;
    w_done  = 1'b0;
    s_axi_awaddr = a; s_axi_awvalid = 1'b1;
    s_axi_wdata = d; s_axi_wstrb = s; s_axi_wvalid = 1'b1;
    for (int k = 0; k < 20 && !(aw_done && w_done); k++) begin
      hs_aw = s_axi_awvalid & s_axi_awready;
      hs_w  = s_axi_wvalid & s_axi_wready;
      tick();
      if (hs_aw) begin s_axi_awvalid = 1'b0; aw_done = 1'b1; end
      if (hs_w)  begin s_axi_wvalid  = 1'b0; w_done  = 1'b1; end
    end
    s_axi_awvalid = 1'b0;
    s_axi_wvalid  = 1'b0;
    chk("aw_w_accept", {aw_done, w_done}, 2'b11);
    wait_b(resp);
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] d, output logic [1:0] r);
    bit hs;
    hs = 1'b0;
    s_axi_araddr = a;
    s_axi_arvalid = 1'b1;
    for (int k = 0; k < 20 && !hs; k++) begin
      hs = s_axi_arready;
      tick();
    end
    s_axi_arvalid = 1'b0;
    chk("ar_accept", hs, 1);
    chk("r_latency", s_axi_rvalid, 1);
    d = s_axi_rdata;
    r = s_axi_rresp;
    s_axi_rready = 1'b1;
    tick();
    s_axi_rready = 1'b0;
  endtask

  logic [1:0]       resp;
  logic [31:0]      rdat;
  logic [NR*DW-1:0] exp_regs;

  initial begin
    aresetn = 1'b0;
    s_axi_awaddr = '0; s_axi_awprot = 3'b000; s_axi_awvalid = 1'b0;
    s_axi_wdata = '0; s_axi_wstrb = '0; s_axi_wvalid = 1'b0;
    s_axi_bready = 1'b0;
    s_axi_araddr = '0; s_axi_arprot = 3'b000; s_axi_arvalid = 1'b0;
    s_axi_rready = 1'b0;
    hw_status = '0;
    hw_status[0*DW +: DW] = 32'h0000_CAFE;
    hw_status[3*DW +: DW] = 32'h1234_5678;

    // reset state
    repeat (3) tick();
    chk("rst_outputs", {s_axi_awready, s_axi_wready, s_axi_arready, s_axi_bvalid,
                        s_axi_rvalid, s_axi_bresp, s_axi_rresp, wr_pulse}, 0);
    chk("rst_rdata", s_axi_rdata, 0);
    chk("rst_slot0_ro", slot(0), 0);
    chk("rst_slot1", slot(1), RSTV);
    aresetn = 1'b1;
    tick();
    chk("ready_after_rst", {s_axi_awready, s_axi_wready, s_axi_arready}, 3'b111);

    // AW and W together; commit and pulse one cycle later, B the cycle after
    take_snap();
    s_axi_awaddr = 32'h4; s_axi_awvalid = 1'b1;
    s_axi_wdata = 32'hDEAD_BEEF; s_axi_wstrb = 4'hF; s_axi_wvalid = 1'b1;
    tick();
    s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
    chk("t1_pulse_commit", wr_pulse, 8'h02);
    chk("t1_no_b_yet", s_axi_bvalid, 0);
    tick();
    chk("t1_pulse_gone", wr_pulse, 0);
    chk("t1_bvalid", s_axi_bvalid, 1);
    chk("t1_bresp", s_axi_bresp, 2'b00);
    chk("t1_slot1", slot(1), 32'hDEAD_BEEF);
    chk("t1_pulse_cycles", pcnt[1] - snap[1], 1);
    s_axi_bready = 1'b1;
    tick();
    s_axi_bready = 1'b0;
    chk("t1_b_done", s_axi_bvalid, 0);
    rd(32'h4, rdat, resp);
    chk("t1_rdata", rdat, 32'hDEAD_BEEF);
    chk("t1_rresp", resp, 2'b00);

    // W ahead of AW, partial strobes
    wr(32'h8, 32'hAABB_CCDD, 4'hF, resp);
    chk("t2_pre_resp", resp, 2'b00);
    s_axi_wdata = 32'h1122_3344; s_axi_wstrb = 4'b0101; s_axi_wvalid = 1'b1;
    tick();
    s_axi_wvalid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk("t2_wready_low", s_axi_wready, 0);
      chk("t2_awready_high", s_axi_awready, 1);
      tick();
    end
    s_axi_awaddr = 32'h8; s_axi_awvalid = 1'b1;
    tick();
    s_axi_awvalid = 1'b0;
    wait_b(resp);
    chk("t2_bresp", resp, 2'b00);
    chk("t2_slot2", slot(2), 32'hAA22_CC44);
    rd(32'h8, rdat, resp);
    chk("t2_rdata", rdat, 32'hAA22_CC44);

    // read-only slot
    take_snap();
    wr(32'h0, 32'h1234_5678, 4'hF, resp);
    chk("t3_bresp_slverr", resp, 2'b10);
    chk("t3_no_pulse", pulsed(), 0);
    chk("t3_slot0", slot(0), 0);
    rd(32'h0, rdat, resp);
    chk("t3_rdata_hw", rdat, 32'h0000_CAFE);
    chk("t3_rresp", resp, 2'b00);

    // out of range, last register, ignored low address bits, zero strobe
    take_snap();
    exp_regs = {RSTV, RSTV, RSTV, RSTV, RSTV, 32'hAA22_CC44, 32'hDEAD_BEEF, 32'h0};
    wr(32'h20, 32'hFFFF_FFFF, 4'hF, resp);
    chk("t4_bresp_decerr", resp, 2'b11);
    chk("t4_regs_same", reg_out, exp_regs);
    chk("t4_no_pulse", pulsed(), 0);
    rd(32'h100, rdat, resp);
    chk("t4_rdata_zero", rdat, 0);
    chk("t4_rresp_decerr", resp, 2'b11);
    rd(32'h1C, rdat, resp);
    chk("t4_last_reg", rdat, RSTV);
    chk("t4_last_rresp", resp, 2'b00);
    rd(32'h5, rdat, resp);
    chk("t4_lowbits_ignored", rdat, 32'hDEAD_BEEF);
    take_snap();
    wr(32'hC, 32'hFFFF_FFFF, 4'h0, resp);
    chk("t4_strb0_resp", resp, 2'b00);
    chk("t4_strb0_pulse", pulsed(), 8'h08);
    chk("t4_strb0_slot3", slot(3), RSTV);

    // bready held low blocks the next write
    s_axi_awaddr = 32'hC; s_axi_awvalid = 1'b1;
    s_axi_wdata = 32'h0BAD_F00D; s_axi_wstrb = 4'hF; s_axi_wvalid = 1'b1;
    tick();
    s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
    tick();
    chk("t5_bvalid", s_axi_bvalid, 1);
    chk("t5_bresp", s_axi_bresp, 2'b00);
    s_axi_awaddr = 32'h10; s_axi_awvalid = 1'b1;
    s_axi_wdata = 32'hCAFE_F00D; s_axi_wvalid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      chk("t5_hold_readies", {s_axi_awready, s_axi_wready, s_axi_bvalid}, 3'b001);
      tick();
    end
    s_axi_bready = 1'b1;
    tick();
    s_axi_bready = 1'b0;
    chk("t5_after_b", {s_axi_bvalid, s_axi_awready, s_axi_wready}, 3'b011);
    tick();
    s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
    wait_b(resp);
    chk("t5_second_resp", resp, 2'b00);
    chk("t5_slot3", slot(3), 32'h0BAD_F00D);
    chk("t5_slot4", slot(4), 32'hCAFE_F00D);

    // read colliding with commit returns the old value
    s_axi_awaddr = 32'h14; s_axi_awvalid = 1'b1;
    s_axi_wdata = 32'h7777_7777; s_axi_wstrb = 4'hF; s_axi_wvalid = 1'b1;
    tick();
    s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
    s_axi_araddr = 32'h14; s_axi_arvalid = 1'b1;
    chk("tc_arready", s_axi_arready, 1);
    tick();
    s_axi_arvalid = 1'b0;
    chk("tc_valids", {s_axi_rvalid, s_axi_bvalid}, 2'b11);
    chk("tc_old_value", s_axi_rdata, RSTV);
    s_axi_rready = 1'b1; s_axi_bready = 1'b1;
    tick();
    s_axi_rready = 1'b0; s_axi_bready = 1'b0;
    chk("tc_slot5", slot(5), 32'h7777_7777);

    // reset mid-transaction
    s_axi_awaddr = 32'h18; s_axi_awvalid = 1'b1;
    s_axi_araddr = 32'h4; s_axi_arvalid = 1'b1;
    tick();
    s_axi_awvalid = 1'b0; s_axi_arvalid = 1'b0;
    chk("t6_pre_rvalid", s_axi_rvalid, 1);
    #2 aresetn = 1'b0;
    #1;
    chk("t6_outs_zero", {s_axi_awready, s_axi_wready, s_axi_arready, s_axi_bvalid,
                         s_axi_rvalid, s_axi_bresp, s_axi_rresp, wr_pulse}, 0);
    chk("t6_rdata_zero", s_axi_rdata, 0);
    chk("t6_slot1_rst", slot(1), RSTV);
    tick();
    aresetn = 1'b1;
    tick();
    s_axi_wdata = 32'h0000_0099; s_axi_wstrb = 4'hF; s_axi_wvalid = 1'b1;
    tick();
    s_axi_wvalid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk("t6_no_stale", {s_axi_bvalid, s_axi_rvalid, wr_pulse}, 0);
      tick();
    end
    s_axi_awaddr = 32'h0; s_axi_awvalid = 1'b1;
    tick();
    s_axi_awvalid = 1'b0;
    wait_b(resp);
    chk("t6_write0_resp", resp, 2'b10);
    wr(32'h4, 32'h600D_CAFE, 4'hF, resp);
    chk("t6_write4_resp", resp, 2'b00);
    chk("t6_slot1", slot(1), 32'h600D_CAFE);
    chk("t6_slot6_untouched", slot(6), RSTV);
    tick();
    chk("t6_no_extra_b", s_axi_bvalid, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
